// File: rtl/poly_voice_engine_pkg.sv
// Shared types and key tuning table for the polyphonic voice engine.
package synth_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ATTACK  = 2'd1,
        SUSTAIN = 2'd2,
        RELEASE = 2'd3
    } voice_state_t;

    typedef enum logic [1:0] {
        WAVE_SAW      = 2'd0,
        WAVE_SQUARE   = 2'd1,
        WAVE_TRIANGLE = 2'd2,
        WAVE_INV_SAW  = 2'd3
    } wave_t;

    localparam int NUM_BASE_KEYS = 13;

    // Divider period per base key at octave shift 0, one saw step per period.
    localparam int KEY_PERIOD [NUM_BASE_KEYS] = '{90, 85, 80, 76, 71, 67, 63, 60, 57, 53, 50, 48, 45};

    // Keys beyond the base table reuse it one octave higher per wrap.
    function automatic int key_period(input int idx);
        return KEY_PERIOD[idx % NUM_BASE_KEYS] >> (idx / NUM_BASE_KEYS);
    endfunction

endpackage

// File: rtl/poly_voice_engine_if.sv
// Control/sample bus between the keypad front end and the voice engine.
interface poly_voice_engine_if #(
    parameter int NUM_KEYS   = 13,
    parameter int NUM_VOICES = 4,
    parameter int SAMPLE_W   = 8
);
    logic [NUM_KEYS-1:0]   keys;
    logic [1:0]            oct_sel;
    logic [1:0]            wave_sel;
    logic                  sample_tick;
    logic [SAMPLE_W-1:0]   mixed_sample;
    logic                  sample_valid;
    logic [NUM_VOICES-1:0] voice_active;

    modport master (
        output keys, oct_sel, wave_sel, sample_tick,
        input  mixed_sample, sample_valid, voice_active
    );

    modport slave (
        input  keys, oct_sel, wave_sel, sample_tick,
        output mixed_sample, sample_valid, voice_active
    );
endinterface

// File: rtl/poly_voice_engine_voice_unit.sv
// One voice: envelope state machine, divider oscillator, wave shaper, amplitude.
module voice_unit
    import synth_pkg::*;
#(
    parameter int NUM_KEYS = 13,
    parameter int SAMPLE_W = 8,
    parameter int DIV_W    = 12,
    parameter int ATK_STEP = 64,
    parameter int REL_STEP = 32,
    parameter int KEY_W    = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic                i_sample_tick,
    input  logic [1:0]          i_oct_sel,
    input  logic [1:0]          i_wave_sel,
    input  logic                i_start,
    input  logic                i_fresh,
    input  logic                i_release,
    input  logic [KEY_W-1:0]    i_key,
    output voice_state_t        o_state,
    output logic [KEY_W-1:0]    o_key,
    output logic [SAMPLE_W-1:0] o_amp
);

    localparam logic [SAMPLE_W-1:0] ENV_MAX = '1;
    localparam logic [SAMPLE_W:0]   ATK_INC = (SAMPLE_W+1)'(ATK_STEP);
    localparam logic [SAMPLE_W:0]   REL_DEC = (SAMPLE_W+1)'(REL_STEP);
    localparam logic [DIV_W-1:0]    DIV_ONE = DIV_W'(1);
    localparam logic [SAMPLE_W-1:0] SAW_ONE = SAMPLE_W'(1);

    voice_state_t          r_state, w_next_state;
    logic [SAMPLE_W-1:0]   r_env, w_next_env;
    logic [DIV_W-1:0]      r_div, w_next_div;
    logic [SAMPLE_W-1:0]   r_saw, w_next_saw;
    logic [KEY_W-1:0]      r_key, w_next_key;
    logic [DIV_W-1:0]      w_tc;
    logic [SAMPLE_W:0]     w_env_up;
    logic [SAMPLE_W-1:0]   w_saw_dbl;
    logic [SAMPLE_W-1:0]   w_wave;
    logic [2*SAMPLE_W-1:0] w_prod;

    assign w_tc      = DIV_W'(key_period(int'(r_key))) << i_oct_sel;
    assign w_env_up  = {1'b0, r_env} + ATK_INC;
    assign w_saw_dbl = {r_saw[SAMPLE_W-2:0], 1'b0};

    // Register the voice state, envelope, oscillator and owned key.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= IDLE;
            r_env   <= '0;
            r_div   <= '0;
            r_saw   <= '0;
            r_key   <= '0;
        end else begin
            r_state <= w_next_state;
            r_env   <= w_next_env;
            r_div   <= w_next_div;
            r_saw   <= w_next_saw;
            r_key   <= w_next_key;
        end
    end

    // Next state: oscillator every clock, envelope on ticks, then note-off over allocation.
    always_comb begin
        w_next_state = r_state;
        w_next_env   = r_env;
        w_next_div   = r_div;
        w_next_saw   = r_saw;
        w_next_key   = r_key;

        if (r_state != IDLE) begin
            if (r_div >= w_tc - DIV_ONE) begin
                w_next_div = '0;
                w_next_saw = r_saw + SAW_ONE;
            end else begin
                w_next_div = r_div + DIV_ONE;
            end
        end

        if (i_sample_tick) begin
            case (r_state)
                ATTACK: begin
                    if (w_env_up >= {1'b0, ENV_MAX}) begin
                        w_next_env   = ENV_MAX;
                        w_next_state = SUSTAIN;
                    end else begin
                        w_next_env = w_env_up[SAMPLE_W-1:0];
                    end
                end
                RELEASE: begin
                    if ({1'b0, r_env} <= REL_DEC) begin
                        w_next_env   = '0;
                        w_next_state = IDLE;
                    end else begin
                        w_next_env = r_env - REL_DEC[SAMPLE_W-1:0];
                    end
                end
                default: ;
            endcase
        end

        if (i_release) begin
            w_next_state = RELEASE;
        end else if (i_start) begin
            w_next_state = ATTACK;
            w_next_key   = i_key;
            if (i_fresh) begin
                w_next_env = '0;
                w_next_div = '0;
                w_next_saw = '0;
            end
        end
    end

    // Shape the saw phase into the selected waveform.
    always_comb begin
        w_wave = r_saw;
        case (wave_t'(i_wave_sel))
            WAVE_SAW:      w_wave = r_saw;
            WAVE_SQUARE:   w_wave = r_saw[SAMPLE_W-1] ? '1 : '0;
            WAVE_TRIANGLE: w_wave = r_saw[SAMPLE_W-1] ? ~w_saw_dbl : w_saw_dbl;
            WAVE_INV_SAW:  w_wave = ~r_saw;
            default:       w_wave = r_saw;
        endcase
    end

    assign w_prod  = {{SAMPLE_W{1'b0}}, w_wave} * {{SAMPLE_W{1'b0}}, r_env};
    assign o_amp   = (r_state == IDLE) ? '0 : SAMPLE_W'(w_prod >> SAMPLE_W);
    assign o_state = r_state;
    assign o_key   = r_key;

endmodule

// File: rtl/poly_voice_engine.sv
// Polyphonic engine top: key edge detect, pending mask, voice allocator and mixer.
module poly_voice_engine
    import synth_pkg::*;
#(
    parameter int NUM_KEYS   = 13,
    parameter int NUM_VOICES = 4,
    parameter int SAMPLE_W   = 8,
    parameter int DIV_W      = 12,
    parameter int ATK_STEP   = 64,
    parameter int REL_STEP   = 32
) (
    input logic              clk,
    input logic              nrst,
    poly_voice_engine_if.slave bus
);

    localparam int KEY_W     = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
    localparam int VOICE_W   = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int MIX_SHIFT = $clog2(NUM_VOICES);
    localparam int SUM_W     = SAMPLE_W + MIX_SHIFT;

    logic [NUM_KEYS-1:0]   r_key_prev, r_pending;
    logic [NUM_KEYS-1:0]   w_rise, w_fall, w_pend_eff, w_clr;
    logic [VOICE_W-1:0]    r_steal_ptr;
    logic [SAMPLE_W-1:0]   r_mixed;
    logic                  r_valid;

    voice_state_t          w_vstate [NUM_VOICES];
    logic [KEY_W-1:0]      w_vkey   [NUM_VOICES];
    logic [SAMPLE_W-1:0]   w_vamp   [NUM_VOICES];
    logic [NUM_VOICES-1:0] w_start, w_fresh, w_release, w_active;

    logic                  w_req_valid;
    logic [KEY_W-1:0]      w_req_key;
    logic                  w_own_hit, w_idle_hit, w_rel_hit;
    logic [VOICE_W-1:0]    w_own_idx, w_idle_idx, w_rel_idx, w_target;
    logic                  w_target_fresh, w_steal_adv;
    logic [SUM_W-1:0]      w_sum;

    assign w_rise     = bus.keys & ~r_key_prev;
    assign w_fall     = ~bus.keys & r_key_prev;
    assign w_pend_eff = r_pending & ~w_fall;

    // Key history, pending note-ons and the round-robin steal pointer.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_key_prev  <= '0;
            r_pending   <= '0;
            r_steal_ptr <= '0;
        end else begin
            r_key_prev <= bus.keys;
            r_pending  <= ((r_pending & ~w_clr) | w_rise) & ~w_fall;
            if (w_steal_adv) begin
                r_steal_ptr <= (r_steal_ptr == VOICE_W'(NUM_VOICES - 1)) ? '0
                                                                         : r_steal_ptr + VOICE_W'(1);
            end
        end
    end

    // Pick the lowest pending key and the voice it lands on: owner, idle, releasing, then steal.
    always_comb begin
        w_req_valid    = 1'b0;
        w_req_key      = '0;
        w_clr          = '0;
        w_own_hit      = 1'b0;
        w_own_idx      = '0;
        w_idle_hit     = 1'b0;
        w_idle_idx     = '0;
        w_rel_hit      = 1'b0;
        w_rel_idx      = '0;
        w_target       = r_steal_ptr;
        w_target_fresh = 1'b0;
        w_steal_adv    = 1'b0;
        w_start        = '0;
        w_fresh        = '0;

        for (int k = NUM_KEYS - 1; k >= 0; k--) begin
            if (w_pend_eff[k]) begin
                w_req_valid = 1'b1;
                w_req_key   = KEY_W'(k);
            end
        end

        for (int v = NUM_VOICES - 1; v >= 0; v--) begin
            if (w_vstate[v] != IDLE && w_vkey[v] == w_req_key) begin
                w_own_hit = 1'b1;
                w_own_idx = VOICE_W'(v);
            end
            if (w_vstate[v] == IDLE) begin
                w_idle_hit = 1'b1;
                w_idle_idx = VOICE_W'(v);
            end
            if (w_vstate[v] == RELEASE) begin
                w_rel_hit = 1'b1;
                w_rel_idx = VOICE_W'(v);
            end
        end

        if (w_own_hit) begin
            w_target = w_own_idx;
        end else if (w_idle_hit) begin
            w_target       = w_idle_idx;
            w_target_fresh = 1'b1;
        end else if (w_rel_hit) begin
            w_target = w_rel_idx;
        end else begin
            w_steal_adv = w_req_valid;
        end

        if (w_req_valid) begin
            w_clr[w_req_key]  = 1'b1;
            w_start[w_target] = 1'b1;
            w_fresh[w_target] = w_target_fresh;
        end
    end

    // Note-off for sounding voices whose key just went up, plus the active map.
    always_comb begin
        w_release = '0;
        w_active  = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            w_release[v] = (w_vstate[v] == ATTACK || w_vstate[v] == SUSTAIN) && w_fall[w_vkey[v]];
            w_active[v]  = (w_vstate[v] != IDLE);
        end
    end

    for (genvar gv = 0; gv < NUM_VOICES; gv++) begin : g_voice
        voice_unit #(
            .NUM_KEYS (NUM_KEYS),
            .SAMPLE_W (SAMPLE_W),
            .DIV_W    (DIV_W),
            .ATK_STEP (ATK_STEP),
            .REL_STEP (REL_STEP),
            .KEY_W    (KEY_W)
        ) u_voice (
            .clk           (clk),
            .nrst          (nrst),
            .i_sample_tick (bus.sample_tick),
            .i_oct_sel     (bus.oct_sel),
            .i_wave_sel    (bus.wave_sel),
            .i_start       (w_start[gv]),
            .i_fresh       (w_fresh[gv]),
            .i_release     (w_release[gv]),
            .i_key         (w_req_key),
            .o_state       (w_vstate[gv]),
            .o_key         (w_vkey[gv]),
            .o_amp         (w_vamp[gv])
        );
    end

    // Sum every voice amplitude in a width that cannot overflow.
    always_comb begin
        w_sum = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            w_sum = w_sum + SUM_W'(w_vamp[v]);
        end
    end

    // Capture the normalised mix on each sample tick and flag it one cycle later.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_mixed <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= bus.sample_tick;
            if (bus.sample_tick) begin
                r_mixed <= SAMPLE_W'(w_sum >> MIX_SHIFT);
            end
        end
    end

    assign bus.mixed_sample = r_mixed;
    assign bus.sample_valid = r_valid;
    assign bus.voice_active = w_active;

endmodule
